// File: rtl/tmr_reg_bank_scrub.sv
// tmr_reg_bank_scrub
// Triple-modular-redundant register bank with a background scrubber.
// Every register is held in three replicas; the SoC sees the bitwise
// majority. A scrub pass walks all registers once, rewrites any register
// whose replicas disagree with the majority and counts the corrections.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   req_i/we_i/addr_i/be_i/wdata_i   bus request (no backpressure)
//   gnt_o                   grant (= req_i)
//   rvalid_o/rdata_o/err_o  response, one cycle after grant
//   hw_we_i/hw_wdata_i      per-register full-width hardware writes
//   reg_value_o             voted register values, packed
//   scrub_req_i             force a scrub pass (sampled while idle)
//   scrub_busy_o            scrub pass in progress
//   fault_o/fault_cnt_o     correction pulse / saturating correction count
//   inj_*                   fault injection into one replica (XOR mask)
module tmr_reg_bank_scrub #(
    parameter int                           NumRegs       = 8,
    parameter int                           DataWidth     = 32,
    parameter logic [NumRegs*DataWidth-1:0] ResetValue    = '0,
    parameter int                           ScrubInterval = 1024,
    parameter int                           FaultCntWidth = 8,
    localparam int                          AddrWidth     = $clog2(NumRegs)
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           req_i,
    input  logic                           we_i,
    input  logic [AddrWidth-1:0]           addr_i,
    input  logic [DataWidth/8-1:0]         be_i,
    input  logic [DataWidth-1:0]           wdata_i,
    output logic                           gnt_o,
    output logic                           rvalid_o,
    output logic [DataWidth-1:0]           rdata_o,
    output logic                           err_o,
    input  logic [NumRegs-1:0]             hw_we_i,
    input  logic [NumRegs*DataWidth-1:0]   hw_wdata_i,
    output logic [NumRegs*DataWidth-1:0]   reg_value_o,
    input  logic                           scrub_req_i,
    output logic                           scrub_busy_o,
    output logic                           fault_o,
    output logic [FaultCntWidth-1:0]       fault_cnt_o,
    input  logic                           inj_en_i,
    input  logic [1:0]                     inj_replica_i,
    input  logic [AddrWidth-1:0]           inj_idx_i,
    input  logic [DataWidth-1:0]           inj_mask_i
);

    localparam int NumBytes = DataWidth / 8;
    // Interval counter only ever needs to reach ScrubInterval-1.
    localparam int CntW = (ScrubInterval > 1) ? $clog2(ScrubInterval) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'((ScrubInterval > 0) ? ScrubInterval - 1 : 0);
    // One extra bit so a power-of-two NumRegs does not wrap to zero.
    localparam logic [AddrWidth:0] NumRegsA = (AddrWidth + 1)'(NumRegs);
    localparam logic [AddrWidth-1:0] LastIdx = AddrWidth'(NumRegs - 1);

    typedef enum logic {IDLE, SCRUB} state_e;

    state_e                   state_q;
    logic                     busy_q;
    logic [CntW-1:0]          icnt_q;
    logic [AddrWidth-1:0]     sidx_q;
    logic                     fault_q;
    logic [FaultCntWidth-1:0] fcnt_q;
    logic                     rvalid_q;
    logic                     err_q;
    logic [DataWidth-1:0]     rdata_q;

    logic [DataWidth-1:0] rep_q [3][NumRegs];
    logic [DataWidth-1:0] voted [NumRegs];
    logic [NumRegs-1:0]   diverge;
    logic [NumRegs-1:0]   bus_hit;
    logic [NumRegs-1:0]   inj_hit;
    logic [NumRegs-1:0]   scrub_fix;
    logic [DataWidth-1:0] rd_sel;
    logic [DataWidth-1:0] wr_merged;
    logic                 addr_ok;
    logic                 bus_wr;
    logic                 auto_go;

    // ---------------- voting ----------------
    always_comb begin
        for (int k = 0; k < NumRegs; k++) begin
            voted[k]   = (rep_q[0][k] & rep_q[1][k]) | (rep_q[0][k] & rep_q[2][k])
                       | (rep_q[1][k] & rep_q[2][k]);
            diverge[k] = (rep_q[0][k] != voted[k]) || (rep_q[1][k] != voted[k])
                       || (rep_q[2][k] != voted[k]);
        end
    end

    for (genvar k = 0; k < NumRegs; k++) begin : g_out
        assign reg_value_o[k*DataWidth +: DataWidth] = voted[k];
    end

    // ---------------- bus decode ----------------
    assign gnt_o   = req_i;
    assign addr_ok = ({1'b0, addr_i} < NumRegsA);
    assign bus_wr  = req_i && we_i && addr_ok;

    // Mux by compare so an out-of-range address never indexes the array.
    always_comb begin
        rd_sel = '0;
        for (int k = 0; k < NumRegs; k++) begin
            if (addr_i == AddrWidth'(k)) rd_sel = voted[k];
        end
        wr_merged = rd_sel;
        for (int b = 0; b < NumBytes; b++) begin
            if (be_i[b]) wr_merged[b*8 +: 8] = wdata_i[b*8 +: 8];
        end
    end

    // Per-register event decode; scrub only fixes a register nothing else touches.
    always_comb begin
        for (int k = 0; k < NumRegs; k++) begin
            bus_hit[k]   = bus_wr && (addr_i == AddrWidth'(k));
            inj_hit[k]   = inj_en_i && (inj_replica_i != 2'd3) && (inj_idx_i == AddrWidth'(k));
            scrub_fix[k] = (state_q == SCRUB) && (sidx_q == AddrWidth'(k)) && diverge[k]
                         && !hw_we_i[k] && !bus_hit[k] && !inj_hit[k];
        end
    end

    // ---------------- replica storage ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int r = 0; r < 3; r++)
                for (int k = 0; k < NumRegs; k++)
                    rep_q[r][k] <= ResetValue[k*DataWidth +: DataWidth];
        end else begin
            for (int k = 0; k < NumRegs; k++) begin
                if (hw_we_i[k]) begin
                    for (int r = 0; r < 3; r++) rep_q[r][k] <= hw_wdata_i[k*DataWidth +: DataWidth];
                end else if (bus_hit[k]) begin
                    for (int r = 0; r < 3; r++) rep_q[r][k] <= wr_merged;
                end else if (inj_hit[k]) begin
                    for (int r = 0; r < 3; r++)
                        if (inj_replica_i == 2'(r)) rep_q[r][k] <= rep_q[r][k] ^ inj_mask_i;
                end else if (scrub_fix[k]) begin
                    for (int r = 0; r < 3; r++) rep_q[r][k] <= voted[k];
                end
            end
        end
    end

    // ---------------- bus response ----------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rvalid_q <= 1'b0;
            err_q    <= 1'b0;
            rdata_q  <= '0;
        end else begin
            rvalid_q <= req_i;
            err_q    <= req_i && !addr_ok;
            rdata_q  <= (req_i && !we_i && addr_ok) ? rd_sel : '0;
        end
    end

    assign rvalid_o = rvalid_q;
    assign err_o    = err_q;
    assign rdata_o  = rdata_q;

    // ---------------- scrub FSM ----------------
    assign auto_go = (ScrubInterval != 0) && (icnt_q == CntLast);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            icnt_q  <= '0;
            sidx_q  <= '0;
            fault_q <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            fault_q <= |scrub_fix;
            if ((|scrub_fix) && (fcnt_q != '1)) fcnt_q <= fcnt_q + 1'b1;
            case (state_q)
                IDLE: begin
                    if (scrub_req_i || auto_go) begin
                        state_q <= SCRUB;
                        busy_q  <= 1'b1;
                        sidx_q  <= '0;
                        icnt_q  <= '0;
                    end else begin
                        icnt_q  <= icnt_q + 1'b1;
                    end
                end
                SCRUB: begin
                    if (sidx_q == LastIdx) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        icnt_q  <= '0;
                    end else begin
                        sidx_q  <= sidx_q + 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign scrub_busy_o = busy_q;
    assign fault_o      = fault_q;
    assign fault_cnt_o  = fcnt_q;

endmodule
